parc_core_scoreboard: RTL and testbench
=======================================

Name: parc_core_scoreboard

Overview:
- In-order issue scoreboard that sits in D, directly upstream of the reorder buffer.
- Tracks, per architectural register, the newest in-flight producer: its ROB slot, functional-unit class, and position in the fixed X0-X3/W back end.
- Drives the D-stage hazard stall, per-operand bypass selects, and the ROB allocation request.
- Clears an entry on ROB commit only when the commit tag matches the newest producer.

Parameters:
- NREGS, 32, architectural registers (r0 is never pending)
- NSLOTS, 16, ROB slots; slot tag width = 4

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_val_Dhl  in  1  valid instruction in D
- rs0_ren / rs1_ren  in  1 each  source-operand read enables
- rs0_addr / rs1_addr  in  5 each  source registers
- rd_wen  in  1  instruction writes a register
- rd_addr  in  5  destination register
- fu_type  in  2  0=ALU (ready after X0), 1=MEM (ready after X1), 2=MUL (ready after X3); 3 is illegal and treated as MUL
- rob_alloc_req_val  out  1  allocate request to ROB
- rob_alloc_req_rdy  in  1  ROB can allocate
- rob_alloc_resp_slot  in  4  slot granted this cycle
- rob_commit_wen  in  1  ROB commits head
- rob_commit_slot  in  4  committed slot
- rob_commit_rf_waddr  in  5  committed destination
- stall_Dhl  out  1  hold D this cycle
- op0_byp_sel / op1_byp_sel  out  3 each  0=RF, 1=X0, 2=X1, 3=X2, 4=X3, 5=W, 6=ROB
- op0_rob_slot / op1_rob_slot  out  4 each  slot to read when sel=6

Behaviour:
- Per-register state:
  - pending (1)
  - slot (4)
  - fu (2)
  - stage (5-bit one-hot X0..W; all-zero means result resident in ROB)
- Every instruction traverses X0, X1, X2, X3, W in consecutive cycles; the back end never stalls. Stage vectors therefore shift left every cycle, and W shifts out to zero. This gives no write-port structural hazard.
- Available stage index: ALU=0, MEM=1, MUL=3. An operand is available if stage index >= fu ready index, or if the stage vector is zero.
- RAW hazard on source s: ren && addr!=0 && pending[addr] && !available.
- Alloc hazard: rd_wen && !rob_alloc_req_rdy.
- stall_Dhl = inst_val_Dhl && (RAW on either source || alloc hazard). Combinational, same cycle.
- rob_alloc_req_val = inst_val_Dhl && rd_wen && rd_addr!=0 && !stall_Dhl.
- Writes to r0 allocate nothing and set nothing.
- Issue fires when inst_val_Dhl && !stall_Dhl. If it writes, then at the next edge: pending=1, slot=rob_alloc_resp_slot, fu=fu_type, stage=X0 (one-hot bit 0). This overwrites any older producer (WAW allowed; the ROB orders commits).
- Commit: at the edge, clear pending[rob_commit_rf_waddr] only if pending && slot==rob_commit_slot. A mismatch means a newer producer exists, so the entry is kept.
- Simultaneous issue-write and commit to the same register: issue wins and the entry holds the new tag.
- Bypass select:
  - not pending → 0 (RF)
  - pending → stage index+1
  - pending with zero stage vector → 6, with opN_rob_slot = slot
  - When stalled, the select value is don't-care but must still be deterministic.
- Same-cycle commit of the producer being read: the scoreboard uses the pre-edge state (sel=6). The ROB guarantees data stays readable during its commit cycle.
- Reset: all pending=0, all stage vectors=0. Outputs settle to stall_Dhl=0, rob_alloc_req_val=0, selects=0 (given inst_val_Dhl=0). Reset mid-operation discards all in-flight tracking.

Optional Feature:
- PARC_SCOREBOARD_BYPASS_EN defined: bypass behaviour as above.
- PARC_SCOREBOARD_BYPASS_EN undefined: the operand is never available while pending; selects are tied to 0 and any pending source stalls until commit clears it.

Decomposition:
- Package parc_scoreboard_pkg holds:
  - fu_type encodings
  - ready-index constants (ALU=0, MEM=1, MUL=3)
  - byp_sel encodings (RF..ROB)
  - stage one-hot width 5
  - slot width 4
- One sub-module: parc_scoreboard_entry (one register's state, shift, set/clear logic, available flag), instantiated NREGS-1 times. r0 is hard-wired not pending.

Test Plan:
- ALU writes r3 (slot 0); next instruction reads r3 → stall_Dhl=0, op0_byp_sel=1 (X0).
- MUL writes r5; next instruction reads r5 → stall for 3 cycles (X0, X1, X2), then sel=4 (X3) with no stall.
- MEM writes r7, no commit, read r7 after 6 cycles → sel=6, op_rob_slot=tagged slot.
- Issue r4 with slot 2, then r4 again with slot 3; commit slot 2 on r4 → pending stays set with slot 3; commit slot 3 → pending cleared, sel=0.
- rob_alloc_req_rdy=0 with rd_wen=1 → stall_Dhl=1, rob_alloc_req_val=0. An instruction with no destination does not stall.
- Assert reset with 3 pending registers → next cycle all selects=0 and no stalls.
- Without the macro: ALU to r3, read r3 → stalls until the commit of r3's slot.

Source files
------------

// File: rtl/parc_scoreboard_pkg.sv
// rtl/parc_scoreboard_pkg.sv - shared encodings and helpers for the PARC issue scoreboard
package parc_scoreboard_pkg;

    localparam int STAGE_W = 5;
    localparam int SLOT_W  = 4;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MEM = 2'd1;
    localparam logic [1:0] FU_MUL = 2'd2;
    localparam logic [1:0] FU_ILL = 2'd3;

    localparam logic [2:0] RDY_ALU = 3'd0;
    localparam logic [2:0] RDY_MEM = 3'd1;
    localparam logic [2:0] RDY_MUL = 3'd3;

    localparam logic [2:0] BYP_RF  = 3'd0;
    localparam logic [2:0] BYP_X0  = 3'd1;
    localparam logic [2:0] BYP_X1  = 3'd2;
    localparam logic [2:0] BYP_X2  = 3'd3;
    localparam logic [2:0] BYP_X3  = 3'd4;
    localparam logic [2:0] BYP_W   = 3'd5;
    localparam logic [2:0] BYP_ROB = 3'd6;

    // The illegal encoding is treated as the slowest unit.
    function automatic logic [2:0] fu_ready_idx(input logic [1:0] fu);
        case (fu)
            FU_ALU:  return RDY_ALU;
            FU_MEM:  return RDY_MEM;
            default: return RDY_MUL;
        endcase
    endfunction

    function automatic logic [2:0] stage_byp_sel(input logic [STAGE_W-1:0] stage);
        case (stage)
            5'b00001: return BYP_X0;
            5'b00010: return BYP_X1;
            5'b00100: return BYP_X2;
            5'b01000: return BYP_X3;
            5'b10000: return BYP_W;
            default:  return BYP_ROB;
        endcase
    endfunction

endpackage

// File: rtl/parc_scoreboard_entry.sv
// rtl/parc_scoreboard_entry.sv - one register's producer tracking; PARC_SCOREBOARD_BYPASS_EN enables forwarding
module parc_scoreboard_entry
    import parc_scoreboard_pkg::*;
#(
    parameter int SW = SLOT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_i,
    input  logic [SW-1:0] set_slot_i,
    input  logic [1:0]    set_fu_i,
    input  logic          commit_wen_i,
    input  logic [SW-1:0] commit_slot_i,
    output logic          pending_o,
    output logic [SW-1:0] slot_o,
    output logic          available_o,
    output logic [2:0]    byp_sel_o
);

`ifdef PARC_SCOREBOARD_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic               pending_q, pending_d;
    logic [SW-1:0]      slot_q, slot_d;
    logic [1:0]         fu_q, fu_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [STAGE_W-1:0] ready_mask;

    always_comb begin
        pending_d = pending_q;
        slot_d    = slot_q;
        fu_d      = fu_q;
        stage_d   = {stage_q[STAGE_W-2:0], 1'b0};
        // A stale tag means a newer producer owns the register; keep it.
        if (commit_wen_i && pending_q && (slot_q == commit_slot_i))
            pending_d = 1'b0;
        if (set_i) begin
            pending_d = 1'b1;
            slot_d    = set_slot_i;
            fu_d      = set_fu_i;
            stage_d   = 5'b00001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            slot_q    <= '0;
            fu_q      <= FU_ALU;
            stage_q   <= '0;
        end else begin
            pending_q <= pending_d;
            slot_q    <= slot_d;
            fu_q      <= fu_d;
            stage_q   <= stage_d;
        end
    end

    assign ready_mask  = 5'b11111 << fu_ready_idx(fu_q);
    assign available_o = BYPASS_EN && ((stage_q == '0) || (|(stage_q & ready_mask)));
    assign byp_sel_o   = (BYPASS_EN && pending_q) ? stage_byp_sel(stage_q) : BYP_RF;
    assign pending_o   = pending_q;
    assign slot_o      = slot_q;

endmodule

// File: rtl/parc_core_scoreboard.sv
// rtl/parc_core_scoreboard.sv - D-stage issue scoreboard; forwarding gated by PARC_SCOREBOARD_BYPASS_EN
module parc_core_scoreboard
    import parc_scoreboard_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NSLOTS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inst_val_Dhl,
    input  logic                      rs0_ren,
    input  logic                      rs1_ren,
    input  logic [4:0]                rs0_addr,
    input  logic [4:0]                rs1_addr,
    input  logic                      rd_wen,
    input  logic [4:0]                rd_addr,
    input  logic [1:0]                fu_type,
    output logic                      rob_alloc_req_val,
    input  logic                      rob_alloc_req_rdy,
    input  logic [$clog2(NSLOTS)-1:0] rob_alloc_resp_slot,
    input  logic                      rob_commit_wen,
    input  logic [$clog2(NSLOTS)-1:0] rob_commit_slot,
    input  logic [4:0]                rob_commit_rf_waddr,
    output logic                      stall_Dhl,
    output logic [2:0]                op0_byp_sel,
    output logic [2:0]                op1_byp_sel,
    output logic [$clog2(NSLOTS)-1:0] op0_rob_slot,
    output logic [$clog2(NSLOTS)-1:0] op1_rob_slot
);

    localparam int SW = $clog2(NSLOTS);

    logic          pend  [NREGS];
    logic          avail [NREGS];
    logic [SW-1:0] slot  [NREGS];
    logic [2:0]    sel   [NREGS];

    logic raw0, raw1, alloc_hazard;

    // r0 is architecturally constant, so it never has a producer.
    assign pend[0]  = 1'b0;
    assign avail[0] = 1'b1;
    assign slot[0]  = '0;
    assign sel[0]   = BYP_RF;

    for (genvar r = 1; r < NREGS; r++) begin : g_ent
        parc_scoreboard_entry #(.SW(SW)) u_entry (
            .clk           (clk),
            .reset         (reset),
            .set_i         (rob_alloc_req_val && (rd_addr == 5'(r))),
            .set_slot_i    (rob_alloc_resp_slot),
            .set_fu_i      (fu_type),
            .commit_wen_i  (rob_commit_wen && (rob_commit_rf_waddr == 5'(r))),
            .commit_slot_i (rob_commit_slot),
            .pending_o     (pend[r]),
            .slot_o        (slot[r]),
            .available_o   (avail[r]),
            .byp_sel_o     (sel[r])
        );
    end

    assign raw0         = rs0_ren && (rs0_addr != 5'd0) && pend[rs0_addr] && !avail[rs0_addr];
    assign raw1         = rs1_ren && (rs1_addr != 5'd0) && pend[rs1_addr] && !avail[rs1_addr];
    assign alloc_hazard = rd_wen && !rob_alloc_req_rdy;

    assign stall_Dhl         = inst_val_Dhl && (raw0 || raw1 || alloc_hazard);
    assign rob_alloc_req_val = inst_val_Dhl && rd_wen && (rd_addr != 5'd0) && !stall_Dhl;

    assign op0_byp_sel  = sel[rs0_addr];
    assign op1_byp_sel  = sel[rs1_addr];
    assign op0_rob_slot = slot[rs0_addr];
    assign op1_rob_slot = slot[rs1_addr];

endmodule

// File: tb/tb_parc_core_scoreboard.sv
// tb/tb_parc_core_scoreboard.sv - directed and randomized bench against an age-based scoreboard model
module tb_parc_core_scoreboard;

`ifdef PARC_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       inst_val_Dhl, rs0_ren, rs1_ren, rd_wen, rob_alloc_req_rdy, rob_commit_wen;
    logic [4:0] rs0_addr, rs1_addr, rd_addr, rob_commit_rf_waddr;
    logic [1:0] fu_type;
    logic [3:0] rob_alloc_resp_slot, rob_commit_slot;
    logic       rob_alloc_req_val, stall_Dhl;
    logic [2:0] op0_byp_sel, op1_byp_sel;
    logic [3:0] op0_rob_slot, op1_rob_slot;

    always #5 clk = ~clk;

    parc_core_scoreboard dut (
        .clk(clk), .reset(reset), .inst_val_Dhl(inst_val_Dhl),
        .rs0_ren(rs0_ren), .rs1_ren(rs1_ren), .rs0_addr(rs0_addr), .rs1_addr(rs1_addr),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .fu_type(fu_type),
        .rob_alloc_req_val(rob_alloc_req_val), .rob_alloc_req_rdy(rob_alloc_req_rdy),
        .rob_alloc_resp_slot(rob_alloc_resp_slot), .rob_commit_wen(rob_commit_wen),
        .rob_commit_slot(rob_commit_slot), .rob_commit_rf_waddr(rob_commit_rf_waddr),
        .stall_Dhl(stall_Dhl), .op0_byp_sel(op0_byp_sel), .op1_byp_sel(op1_byp_sel),
        .op0_rob_slot(op0_rob_slot), .op1_rob_slot(op1_rob_slot)
    );

    int checks = 0;
    int failures = 0;

    // Model: each register remembers its newest producer and how many cycles ago it issued.
    bit m_pend [32];
    int m_slot [32];
    int m_fu   [32];
    int m_age  [32];

    int obs_stall, obs_alloc, obs_sel0, obs_sel1, obs_slot0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ready_cycles(input int fu);
        if (fu == 0) return 0;
        if (fu == 1) return 1;
        return 3;
    endfunction

    function automatic bit m_raw(input bit ren, input int a);
        return ren && a != 0 && m_pend[a] && !(BYP && m_age[a] >= ready_cycles(m_fu[a]));
    endfunction

    function automatic int m_sel(input int a);
        if (a == 0 || !m_pend[a] || !BYP) return 0;
        if (m_age[a] >= 5) return 6;
        return m_age[a] + 1;
    endfunction

    function automatic bit m_stall();
        return inst_val_Dhl && (m_raw(rs0_ren, rs0_addr) || m_raw(rs1_ren, rs1_addr) ||
                                (rd_wen && !rob_alloc_req_rdy));
    endfunction

    function automatic bit m_alloc();
        return inst_val_Dhl && rd_wen && rd_addr != 0 && !m_stall();
    endfunction

    task automatic model_edge();
        bit fire;
        fire = m_alloc();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_pend[i] = 1'b0;
                m_age[i]  = 99;
            end
        end else begin
            for (int i = 0; i < 32; i++)
                if (m_age[i] < 99) m_age[i]++;
            if (rob_commit_wen && m_pend[rob_commit_rf_waddr] &&
                m_slot[rob_commit_rf_waddr] == int'(rob_commit_slot))
                m_pend[rob_commit_rf_waddr] = 1'b0;
            if (fire) begin
                m_pend[rd_addr] = 1'b1;
                m_slot[rd_addr] = rob_alloc_resp_slot;
                m_fu[rd_addr]   = fu_type;
                m_age[rd_addr]  = 0;
            end
        end
    endtask

    // Inputs are already driven; sample outputs mid-cycle, then advance the model with the edge.
    task automatic step();
        int es0;
        @(negedge clk);
        obs_stall = stall_Dhl;
        obs_alloc = rob_alloc_req_val;
        obs_sel0  = op0_byp_sel;
        obs_sel1  = op1_byp_sel;
        obs_slot0 = op0_rob_slot;
        es0 = m_sel(rs0_addr);
        check("stall", obs_stall, m_stall());
        check("alloc_val", obs_alloc, m_alloc());
        check("op0_sel", obs_sel0, es0);
        check("op1_sel", obs_sel1, m_sel(rs1_addr));
        if (es0 == 6) check("op0_rob_slot", obs_slot0, m_slot[rs0_addr]);
        if (m_sel(rs1_addr) == 6) check("op1_rob_slot", op1_rob_slot, m_slot[rs1_addr]);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 0; inst_val_Dhl = 0; rs0_ren = 0; rs1_ren = 0; rs0_addr = 0; rs1_addr = 0;
        rd_wen = 0; rd_addr = 0; fu_type = 0; rob_alloc_req_rdy = 1; rob_alloc_resp_slot = 0;
        rob_commit_wen = 0; rob_commit_slot = 0; rob_commit_rf_waddr = 0;
    endtask

    task automatic wr(input int rd, input int fu, input int slot);
        idle(); inst_val_Dhl = 1; rd_wen = 1; rd_addr = 5'(rd); fu_type = 2'(fu);
        rob_alloc_resp_slot = 4'(slot);
        step();
    endtask

    task automatic rd0(input int a);
        idle(); inst_val_Dhl = 1; rs0_ren = 1; rs0_addr = 5'(a);
    endtask

    task automatic commit(input int a, input int slot);
        idle(); rob_commit_wen = 1; rob_commit_rf_waddr = 5'(a); rob_commit_slot = 4'(slot);
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0; m_slot[i] = 0; m_fu[i] = 0; m_age[i] = 99;
        end
        idle(); reset = 1;
        @(posedge clk); model_edge(); #1;
        step();
        check("reset_stall", obs_stall, 0);
        check("reset_alloc", obs_alloc, 0);
        check("reset_sel", obs_sel0, 0);

        // ALU producer followed by a consumer
        wr(3, 0, 0);
        rd0(3); step();
        check("alu_stall", obs_stall, BYP ? 0 : 1);
        check("alu_sel", obs_sel0, BYP ? 1 : 0);
        rd0(3); step();
        rd0(3); rob_commit_wen = 1; rob_commit_rf_waddr = 3; rob_commit_slot = 0; step();
        check("commit_cycle_stall", obs_stall, BYP ? 0 : 1);
        rd0(3); step();
        check("after_commit_stall", obs_stall, 0);
        check("after_commit_sel", obs_sel0, 0);

        // MUL producer: three stall cycles, then X3 forwarding
        wr(5, 2, 1);
        for (int k = 0; k < 3; k++) begin
            idle(); inst_val_Dhl = 1; rs1_ren = 1; rs1_addr = 5; step();
            check("mul_stall", obs_stall, 1);
        end
        idle(); inst_val_Dhl = 1; rs1_ren = 1; rs1_addr = 5; step();
        check("mul_x3_stall", obs_stall, BYP ? 0 : 1);
        check("mul_x3_sel", obs_sel1, BYP ? 4 : 0);

        // MEM producer left in the ROB
        wr(7, 1, 9);
        for (int k = 0; k < 5; k++) begin idle(); step(); end
        rd0(7); step();
        check("rob_sel", obs_sel0, BYP ? 6 : 0);
        if (BYP) check("rob_slot", obs_slot0, 9);

        // WAW with a stale commit
        wr(4, 0, 2);
        wr(4, 0, 3);
        commit(4, 2);
        rd0(4); step();
        check("waw_kept_stall", obs_stall, BYP ? 0 : 1);
        check("waw_kept_sel", obs_sel0, BYP ? 2 : 0);
        commit(4, 3);
        rd0(4); step();
        check("waw_cleared_stall", obs_stall, 0);
        check("waw_cleared_sel", obs_sel0, 0);

        // ROB full
        idle(); inst_val_Dhl = 1; rd_wen = 1; rd_addr = 8; rob_alloc_req_rdy = 0; step();
        check("full_stall", obs_stall, 1);
        check("full_alloc", obs_alloc, 0);
        idle(); inst_val_Dhl = 1; rs0_ren = 1; rs0_addr = 9; rob_alloc_req_rdy = 0; step();
        check("full_nodest_stall", obs_stall, 0);
        idle(); inst_val_Dhl = 1; rd_wen = 1; rd_addr = 0; step();
        check("r0_alloc", obs_alloc, 0);
        rd0(0); step();
        check("r0_sel", obs_sel0, 0);

        // Reset with pending producers
        wr(10, 2, 4); wr(11, 1, 5); wr(12, 0, 6);
        idle(); reset = 1; step();
        rd0(10); rs1_ren = 1; rs1_addr = 11; step();
        check("rst_mid_stall", obs_stall, 0);
        check("rst_mid_sel0", obs_sel0, 0);
        check("rst_mid_sel1", obs_sel1, 0);

        for (int n = 0; n < 3000; n++) begin
            int ca;
            idle();
            reset               = ($urandom_range(0, 199) == 0);
            inst_val_Dhl        = ($urandom_range(0, 3) != 0);
            rs0_ren             = $urandom_range(0, 1);
            rs1_ren             = $urandom_range(0, 1);
            rs0_addr            = 5'($urandom_range(0, 15));
            rs1_addr            = 5'($urandom_range(0, 15));
            rd_wen              = $urandom_range(0, 1);
            rd_addr             = 5'($urandom_range(0, 15));
            fu_type             = 2'($urandom_range(0, 3));
            rob_alloc_req_rdy   = ($urandom_range(0, 7) != 0);
            rob_alloc_resp_slot = 4'($urandom_range(0, 15));
            ca                  = $urandom_range(0, 15);
            rob_commit_wen      = ($urandom_range(0, 9) < 4);
            rob_commit_rf_waddr = 5'(ca);
            rob_commit_slot     = $urandom_range(0, 1) ? 4'(m_slot[ca]) : 4'($urandom_range(0, 15));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
